// File: rtl/fir_coeff_ctrl_pkg.sv
// Shared types and helpers for the FIR coefficient controller.
package fir_coeff_ctrl_pkg;

  // Commit sequencer states.
  typedef enum logic [1:0] {
    StIdle,
    StWaitStrobe,
    StSwap
  } state_e;

  // LSB position of a tap inside a packed coefficient bank.
  function automatic int unsigned tap_lsb(int unsigned coeff_bits, int unsigned tap);
    return coeff_bits * tap;
  endfunction

endpackage

// File: rtl/fir_coeff_ctrl_if.sv
// Host-side coefficient write / commit handshake.
interface fir_coeff_ctrl_if #(
  parameter int unsigned ADDR_BITS  = 3,
  parameter int unsigned COEFF_BITS = 16
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [ADDR_BITS-1:0]  cfg_addr;
  logic [COEFF_BITS-1:0] cfg_data;
  logic                  cfg_commit;

  modport master (
    output cfg_valid,
    output cfg_addr,
    output cfg_data,
    output cfg_commit,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_addr,
    input  cfg_data,
    input  cfg_commit,
    output cfg_ready
  );
endinterface

// File: rtl/fir_coeff_bank.sv
// NUMBER_OF_TAPS x COEFF_BITS register file: indexed write, parallel load, packed output.
module fir_coeff_bank
  import fir_coeff_ctrl_pkg::*;
#(
  parameter int unsigned NUMBER_OF_TAPS = 7,
  parameter int unsigned COEFF_BITS     = 16,
  parameter int unsigned ADDR_BITS      = 3
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 wr_en,
  input  logic [ADDR_BITS-1:0]                 wr_addr,
  input  logic [COEFF_BITS-1:0]                wr_data,
  input  logic                                 load,
  input  logic [NUMBER_OF_TAPS*COEFF_BITS-1:0] load_data,
  output logic [NUMBER_OF_TAPS*COEFF_BITS-1:0] bank
);

  logic [NUMBER_OF_TAPS*COEFF_BITS-1:0] bank_d, bank_q;

  // Parallel load takes priority; out-of-range addresses match no tap.
  always_comb begin
    bank_d = bank_q;
    if (load) begin
      bank_d = load_data;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NUMBER_OF_TAPS; i++) begin
        if (wr_addr == ADDR_BITS'(i)) begin
          bank_d[tap_lsb(COEFF_BITS, i) +: COEFF_BITS] = wr_data;
        end
      end
    end
  end

  // Bank storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_q <= '0;
    end else begin
      bank_q <= bank_d;
    end
  end

  assign bank = bank_q;

endmodule

// File: rtl/fir_coeff_ctrl.sv
// Shadow/active coefficient controller with sample-boundary commit and enable sequencing.
module fir_coeff_ctrl
  import fir_coeff_ctrl_pkg::*;
#(
  parameter int unsigned NUMBER_OF_TAPS = 7,
  parameter int unsigned COEFF_BITS     = 16,
  parameter int unsigned ADDR_BITS      = 3,
  parameter int unsigned STROBE_TIMEOUT = 1024
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  fir_coeff_ctrl_if.slave                      cfg,
  input  logic                                 cfg_en_req,
  input  logic                                 sample_strobe,
  output logic [NUMBER_OF_TAPS*COEFF_BITS-1:0] coeffs_out,
  output logic                                 filter_en,
  output logic                                 commit_done,
  output logic                                 commit_timeout,
  output logic                                 err_addr
);

  localparam int unsigned CntW = (STROBE_TIMEOUT > 1) ? $clog2(STROBE_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STROBE_TIMEOUT - 1);

  state_e                               state_d, state_q;
  logic [CntW-1:0]                      cnt_d, cnt_q;
  logic                                 timeout_d, timeout_q;
  logic                                 commit_done_q, commit_timeout_q, err_addr_q;
  logic                                 filter_en_q;
  logic                                 wr_fire, addr_ok, commit_fire, bank_load;
  logic [NUMBER_OF_TAPS*COEFF_BITS-1:0] shadow;

  assign cfg.cfg_ready = (state_q == StIdle);
  assign wr_fire       = cfg.cfg_valid & cfg.cfg_ready;
  assign commit_fire   = cfg.cfg_commit & cfg.cfg_ready;
  // Zero-extend so NUMBER_OF_TAPS == 2**ADDR_BITS still compares correctly.
  assign addr_ok       = {1'b0, cfg.cfg_addr} < (ADDR_BITS + 1)'(NUMBER_OF_TAPS);

  fir_coeff_bank #(
    .NUMBER_OF_TAPS (NUMBER_OF_TAPS),
    .COEFF_BITS     (COEFF_BITS),
    .ADDR_BITS      (ADDR_BITS)
  ) u_shadow (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_fire & addr_ok),
    .wr_addr   (cfg.cfg_addr),
    .wr_data   (cfg.cfg_data),
    .load      (1'b0),
    .load_data ('0),
    .bank      (shadow)
  );

  fir_coeff_bank #(
    .NUMBER_OF_TAPS (NUMBER_OF_TAPS),
    .COEFF_BITS     (COEFF_BITS),
    .ADDR_BITS      (ADDR_BITS)
  ) u_active (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (1'b0),
    .wr_addr   ('0),
    .wr_data   ('0),
    .load      (bank_load),
    .load_data (shadow),
    .bank      (coeffs_out)
  );

  // Commit sequencer next state: wait for a strobe (or timeout), then swap for one cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    bank_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (commit_fire) begin
          state_d   = StWaitStrobe;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      StWaitStrobe: begin
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (sample_strobe) begin
          state_d = StSwap;
        end else if (cnt_q == CntMax) begin
          state_d   = StSwap;
          timeout_d = 1'b1;
        end
      end
      StSwap: begin
        bank_load = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state, counter and registered status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= StIdle;
      cnt_q            <= '0;
      timeout_q        <= 1'b0;
      commit_done_q    <= 1'b0;
      commit_timeout_q <= 1'b0;
      err_addr_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      timeout_q        <= timeout_d;
      commit_done_q    <= (state_q == StSwap);
      commit_timeout_q <= (state_q == StSwap) & timeout_q;
      err_addr_q       <= wr_fire & ~addr_ok;
    end
  end

  // Filter enable follows the request only on sample boundaries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filter_en_q <= 1'b0;
    end else if (sample_strobe) begin
      filter_en_q <= cfg_en_req;
    end
  end

  assign filter_en      = filter_en_q;
  assign commit_done    = commit_done_q;
  assign commit_timeout = commit_timeout_q;
  assign err_addr       = err_addr_q;

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed self-checking bench for fir_coeff_ctrl (STROBE_TIMEOUT = 16).
module tb_fir_coeff_ctrl;

  localparam int unsigned Taps  = 7;
  localparam int unsigned CBits = 16;
  localparam int unsigned ABits = 3;

  logic                    clk;
  logic                    reset_n;
  logic                    cfg_en_req;
  logic                    sample_strobe;
  logic [Taps*CBits-1:0]   coeffs_out;
  logic                    filter_en;
  logic                    commit_done;
  logic                    commit_timeout;
  logic                    err_addr;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [Taps*CBits-1:0] Ramp    = 112'h0106_0105_0104_0103_0102_0101_0100;
  localparam logic [Taps*CBits-1:0] RampT2  = 112'h0106_0105_0104_0103_1234_0101_0100;

  fir_coeff_ctrl_if #(.ADDR_BITS(ABits), .COEFF_BITS(CBits)) cfg_bus ();

  fir_coeff_ctrl #(
    .NUMBER_OF_TAPS (Taps),
    .COEFF_BITS     (CBits),
    .ADDR_BITS      (ABits),
    .STROBE_TIMEOUT (16)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg            (cfg_bus.slave),
    .cfg_en_req     (cfg_en_req),
    .sample_strobe  (sample_strobe),
    .coeffs_out     (coeffs_out),
    .filter_en      (filter_en),
    .commit_done    (commit_done),
    .commit_timeout (commit_timeout),
    .err_addr       (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs and samples both live 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n              = 1'b0;
    cfg_bus.cfg_valid    = 1'b0;
    cfg_bus.cfg_addr     = '0;
    cfg_bus.cfg_data     = '0;
    cfg_bus.cfg_commit   = 1'b0;
    cfg_en_req           = 1'b0;
    sample_strobe        = 1'b0;
    step();

    // Reset state
    check_eq("rst_coeffs", coeffs_out, '0);
    check_eq("rst_filter_en", filter_en, 0);
    check_eq("rst_ready", cfg_bus.cfg_ready, 1);
    check_eq("rst_done", commit_done, 0);
    check_eq("rst_timeout", commit_timeout, 0);
    check_eq("rst_err", err_addr, 0);
    reset_n = 1'b1;
    step();

    // Write ramp, commit, strobe after several cycles
    for (int i = 0; i < 7; i++) begin
      cfg_bus.cfg_valid = 1'b1;
      cfg_bus.cfg_addr  = 3'(i);
      cfg_bus.cfg_data  = 16'h0100 + 16'(i);
      step();
    end
    cfg_bus.cfg_valid = 1'b0;
    check_eq("ok_addr_no_err", err_addr, 0);
    cfg_bus.cfg_commit = 1'b1;
    step();
    cfg_bus.cfg_commit = 1'b0;
    check_eq("wait_ready_low", cfg_bus.cfg_ready, 0);
    for (int i = 0; i < 4; i++) step();
    check_eq("wait_coeffs_hold", coeffs_out, '0);
    sample_strobe = 1'b1;
    step();
    sample_strobe = 1'b0;
    check_eq("swap_coeffs_hold", coeffs_out, '0);
    check_eq("swap_no_done", commit_done, 0);
    step();
    check_eq("ramp_coeffs", coeffs_out, Ramp);
    check_eq("ramp_done", commit_done, 1);
    check_eq("ramp_no_timeout", commit_timeout, 0);
    step();
    check_eq("ramp_done_single", commit_done, 0);
    check_eq("ramp_ready_back", cfg_bus.cfg_ready, 1);

    // Out-of-range write
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_addr  = 3'd7;
    cfg_bus.cfg_data  = 16'hFFFF;
    step();
    cfg_bus.cfg_valid = 1'b0;
    check_eq("err_pulse", err_addr, 1);
    step();
    check_eq("err_single", err_addr, 0);
    cfg_bus.cfg_commit = 1'b1;
    step();
    cfg_bus.cfg_commit = 1'b0;
    sample_strobe = 1'b1;
    step();
    sample_strobe = 1'b0;
    step();
    check_eq("err_coeffs_same", coeffs_out, Ramp);
    check_eq("err_commit_done", commit_done, 1);
    step();

    // Timeout-forced commit: SWAP 16 edges after acceptance, done on the 17th
    cfg_bus.cfg_commit = 1'b1;
    step();
    cfg_bus.cfg_commit = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      step();
      check_eq($sformatf("tmo_ready_low_%0d", j), cfg_bus.cfg_ready, 0);
    end
    check_eq("tmo_not_done_early", commit_done, 0);
    step();
    check_eq("tmo_done", commit_done, 1);
    check_eq("tmo_flag", commit_timeout, 1);
    step();
    check_eq("tmo_done_clear", commit_done, 0);
    check_eq("tmo_flag_clear", commit_timeout, 0);

    // Same-cycle write+commit; writes and commits in WAIT_STROBE are ignored
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_addr   = 3'd2;
    cfg_bus.cfg_data   = 16'h1234;
    cfg_bus.cfg_commit = 1'b1;
    step();
    cfg_bus.cfg_addr   = 3'd3;
    cfg_bus.cfg_data   = 16'hAAAA;
    step();
    step();
    cfg_bus.cfg_valid  = 1'b0;
    cfg_bus.cfg_commit = 1'b0;
    sample_strobe = 1'b1;
    step();
    sample_strobe = 1'b0;
    step();
    check_eq("wc_coeffs", coeffs_out, RampT2);
    check_eq("wc_done", commit_done, 1);
    for (int i = 0; i < 3; i++) step();
    check_eq("wc_no_extra_commit", cfg_bus.cfg_ready, 1);
    check_eq("wc_no_extra_done", commit_done, 0);

    // Enable sequencing
    cfg_en_req = 1'b1;
    step();
    step();
    check_eq("en_hold_low", filter_en, 0);
    sample_strobe = 1'b1;
    step();
    sample_strobe = 1'b0;
    check_eq("en_rise", filter_en, 1);
    cfg_en_req = 1'b0;
    step();
    step();
    check_eq("en_hold_high", filter_en, 1);
    sample_strobe = 1'b1;
    step();
    sample_strobe = 1'b0;
    check_eq("en_fall", filter_en, 0);

    // Strobe coincident with SWAP still updates filter_en
    cfg_bus.cfg_commit = 1'b1;
    step();
    cfg_bus.cfg_commit = 1'b0;
    sample_strobe = 1'b1;
    step();
    check_eq("swap_strobe_en_prev", filter_en, 0);
    cfg_en_req = 1'b1;
    step();
    sample_strobe = 1'b0;
    check_eq("swap_strobe_en", filter_en, 1);
    check_eq("swap_strobe_done", commit_done, 1);
    step();

    // Reset during WAIT_STROBE
    cfg_bus.cfg_commit = 1'b1;
    step();
    cfg_bus.cfg_commit = 1'b0;
    step();
    check_eq("mid_ready_low", cfg_bus.cfg_ready, 0);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_coeffs", coeffs_out, '0);
    check_eq("mid_rst_en", filter_en, 0);
    check_eq("mid_rst_ready", cfg_bus.cfg_ready, 1);
    step();
    reset_n = 1'b1;
    cfg_en_req = 1'b0;
    sample_strobe = 1'b1;
    step();
    sample_strobe = 1'b0;
    step();
    check_eq("mid_no_done_a", commit_done, 0);
    step();
    check_eq("mid_no_done_b", commit_done, 0);
    check_eq("mid_coeffs_zero", coeffs_out, '0);
    // Shadow was cleared too: a fresh commit publishes zeros
    cfg_bus.cfg_commit = 1'b1;
    step();
    cfg_bus.cfg_commit = 1'b0;
    sample_strobe = 1'b1;
    step();
    sample_strobe = 1'b0;
    step();
    check_eq("mid_shadow_lost_done", commit_done, 1);
    check_eq("mid_shadow_lost", coeffs_out, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
